// File: rtl/usb_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_mem_pkg : shared defaults and Wishbone-port state encoding for usb_mem_arb
// Revision    : 1.0
// ---------------------------------------------------------------------------
package usb_mem_pkg;

  localparam int AW_DEF         = 15;
  localparam int DW_DEF         = 32;
  localparam int STARVE_LIM_DEF = 8;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_PEND   = 3'd1,
    W_RDWAIT = 3'd2,
    W_ACK    = 3'd3,
    W_TURN   = 3'd4
  } w_state_e;

  function automatic int cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_mem_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_mem_arb_if : USB-engine, Wishbone and SRAM-side buses of the arbiter
// Revision       : 1.0
// ---------------------------------------------------------------------------
interface usb_mem_arb_if
  import usb_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dout;
  logic          m_ack;
  logic [DW-1:0] m_din;

  logic          w_req;
  logic          w_we;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dout;
  logic          w_ack;
  logic [DW-1:0] w_din;

  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] sram_din;
  logic          sram_re;
  logic          sram_we;

  modport slave (
    input  m_req, m_we, m_adr, m_dout,
    output m_ack, m_din,
    input  w_req, w_we, w_adr, w_dout,
    output w_ack, w_din,
    output sram_adr, sram_dout, sram_re, sram_we,
    input  sram_din
  );

  modport master (
    output m_req, m_we, m_adr, m_dout,
    input  m_ack, m_din,
    output w_req, w_we, w_adr, w_dout,
    input  w_ack, w_din,
    input  sram_adr, sram_dout, sram_re, sram_we,
    output sram_din
  );

endinterface
`default_nettype wire

// File: rtl/usb_mem_starve_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_mem_starve_cnt : saturating W wait counter, force_o once LIM is reached
// Revision           : 1.0
// ---------------------------------------------------------------------------
module usb_mem_starve_cnt
  import usb_mem_pkg::*;
#(
  parameter int LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic clr_i,
  output logic force_o
);

  localparam int CW = cnt_w(LIM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != CW'(LIM))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CW'(LIM));

endmodule
`default_nettype wire

// File: rtl/usb_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_mem_arb : SRAM arbiter, USB engine (high prio) vs Wishbone (low prio).
// Revision    : 1.0   Optional W starvation guard: USB_MEM_ARB_FAIR_EN
// ---------------------------------------------------------------------------
module usb_mem_arb
  import usb_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  usb_mem_arb_if.slave  bus
);

  w_state_e      state_q;
  w_state_e      state_d;
  logic [DW-1:0] w_din_q;
  logic [DW-1:0] w_din_d;

  logic          w_force;
  logic          w_pend;
  logic          m_issue;
  logic          w_issue;

  logic [AW-1:0] adr_mux;
  logic [DW-1:0] dout_mux;
  logic          re_mux;
  logic          we_mux;

  assign w_pend  = (state_q == W_PEND);
  assign m_issue = bus.m_req && !w_force;
  assign w_issue = w_pend && !m_issue;

`ifdef USB_MEM_ARB_FAIR_EN
  logic starve_force;

  usb_mem_starve_cnt #(
    .LIM     (STARVE_LIM)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .wait_i  (w_pend && !w_issue),
    .clr_i   (w_issue),
    .force_o (starve_force)
  );

  assign w_force = starve_force && w_pend;
`else
  // Without the fairness guard the limit has no effect; this is constant 0.
  assign w_force = (STARVE_LIM < 0);
`endif

  always_comb begin
    adr_mux   = '0;
    dout_mux  = '0;
    re_mux    = 1'b0;
    we_mux    = 1'b0;
    bus.m_ack = 1'b0;
    if (m_issue) begin
      bus.m_ack = 1'b1;
      adr_mux   = bus.m_adr;
      dout_mux  = bus.m_dout;
      we_mux    = bus.m_we;
      re_mux    = !bus.m_we;
    end else if (w_issue) begin
      adr_mux   = bus.w_adr;
      dout_mux  = bus.w_dout;
      we_mux    = bus.w_we;
      re_mux    = !bus.w_we;
    end
  end

  assign bus.sram_adr  = adr_mux;
  assign bus.sram_dout = dout_mux;
  assign bus.sram_re   = re_mux;
  assign bus.sram_we   = we_mux;

  // No read latch: the SRAM zeroes its output when idle.
  assign bus.m_din = bus.sram_din;

  always_comb begin
    state_d = state_q;
    w_din_d = w_din_q;
    case (state_q)
      W_IDLE: begin
        if (bus.w_req) state_d = W_PEND;
      end
      W_PEND: begin
        if (w_issue) state_d = bus.w_we ? W_ACK : W_RDWAIT;
      end
      W_RDWAIT: begin
        w_din_d = bus.sram_din;
        state_d = W_ACK;
      end
      W_ACK:   state_d = W_TURN;
      // Turnaround ignores w_req so a late-dropped request is not re-issued.
      W_TURN:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      w_din_q <= '0;
    end else begin
      state_q <= state_d;
      w_din_q <= w_din_d;
    end
  end

  assign bus.w_ack = (state_q == W_ACK);
  assign bus.w_din = w_din_q;

endmodule
`default_nettype wire

// File: doc/usb_mem_arb.md
Name: usb_mem_arb

Overview:
- Two-port arbiter directly upstream of the ssram buffer memory (32K x 32, one-cycle registered read).
- Port M is the USB protocol engine: fixed high priority, single-cycle grant.
- Port W is the Wishbone host: lower priority, request/ack handshake with a registered read return.
- Generates the SRAM address, write data, read enable and write enable, and never asserts the two enables together.

Parameters:
- AW, 15, SRAM word-address width.
- DW, 32, data width.
- STARVE_LIM, 8, cycles a W request may wait before it is forced a slot (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  1  USB engine access request
- m_we  in  1  1 = write, 0 = read; valid with m_req
- m_adr  in  AW  USB word address
- m_dout  in  DW  USB write data
- m_ack  out  1  combinational grant for this cycle
- m_din  out  DW  USB read data; equals sram_din, valid the cycle after a read grant
- w_req  in  1  Wishbone request; held until w_ack
- w_we  in  1  Wishbone write select
- w_adr  in  AW  Wishbone word address
- w_dout  in  DW  Wishbone write data
- w_ack  out  1  one-cycle completion pulse
- w_din  out  DW  registered Wishbone read data
- sram_adr  out  AW  to SRAM address input
- sram_dout  out  DW  to SRAM write-data input
- sram_din  in  DW  from SRAM read-data output
- sram_re  out  1  SRAM read enable
- sram_we  out  1  SRAM write enable

Behaviour:
- Reset values: w_ack=0, w_din=0, Wishbone FSM in W_IDLE, starvation counter 0. All SRAM outputs are combinational and read 0 while no access is issued.
- Each cycle, at most one access is issued:
  - If m_req=1 and no forced W slot is active: issue M; m_ack=1; sram_we=m_we; sram_re=!m_we.
  - Otherwise, if the W FSM is in W_PEND: issue W.
  - Otherwise: sram_re=0, sram_we=0, sram_adr=0, sram_dout=0.
- M timing: write commits at the grant edge. Read data appears on m_din the cycle after the grant. There is no data-bus latch; the SRAM zeroes its output when idle, so m_din is valid for exactly one cycle.
- W FSM:
  - W_IDLE -> W_PEND on w_req=1. The request is not latched; w_adr, w_we and w_dout are used live and must be held stable.
  - W_PEND, issued as a write -> W_ACK.
  - W_PEND, issued as a read -> W_RDWAIT.
  - W_PEND, not issued -> stays in W_PEND.
  - W_RDWAIT: w_din <= sram_din; -> W_ACK.
  - W_ACK: w_ack=1 for this cycle only; -> W_TURN.
  - W_TURN: ignores w_req; -> W_IDLE. This turnaround prevents a duplicate access if the master drops w_req late.
- Latency: minimum W write is 3 cycles from w_req to w_ack; minimum W read is 4 cycles.
- Boundary conditions:
  - Simultaneous m_req and W_PEND: M wins; W stays pending.
  - M read immediately followed by a W issue: legal. The SRAM output is registered per access, so there is no bus conflict.
  - Address range 0 to 2^AW-1 is passed through unchanged; there is no wrap logic.
  - Asynchronous reset mid-operation: FSM returns to W_IDLE, no ack is issued, and an in-flight read is discarded.
  - The SRAM enables are mutually exclusive by construction; the bench asserts this every cycle.

Optional Feature:
- Macro: USB_MEM_ARB_FAIR_EN.
- When defined:
  - A counter increments each cycle the FSM is in W_PEND without being issued.
  - When the counter reaches STARVE_LIM, the next cycle is a forced W slot: W is issued and m_ack=0 even if m_req=1. The USB engine retries in the following cycle.
  - The counter clears on every W issue and on reset.
- When undefined: M has absolute priority, W can starve indefinitely, and the counter logic is absent.

Decomposition:
- Shared package usb_mem_pkg holds:
  - the AW/DW defaults;
  - the W FSM state encoding (W_IDLE, W_PEND, W_RDWAIT, W_ACK, W_TURN, 3 bits);
  - the STARVE_LIM default.
- One natural sub-module: usb_mem_starve_cnt, the saturating wait counter with a force output. It is instantiated only under USB_MEM_ARB_FAIR_EN.

Test Plan:
- M write adr 0x0010 data 0xDEADBEEF, then M read 0x0010 -> m_ack=1 both cycles; m_din=0xDEADBEEF one cycle after the read grant; sram_we and sram_re never both high.
- Idle M; W write 0x7FFF=0x12345678, then W read 0x7FFF -> w_ack exactly 3 cycles after the write w_req and 4 cycles after the read w_req; w_din=0x12345678.
- m_req and w_req rise together (M read 0x0001, W write 0x0002) -> M granted first; W issued the next free cycle; w_ack two cycles later; one w_ack pulse only.
- m_req held high for 20 cycles, W read pending:
  - macro off -> no w_ack until m_req drops;
  - macro on with STARVE_LIM=8 -> forced slot with m_ack=0 in that cycle; w_ack follows after the read wait.
- rst_n pulled low while the FSM is in W_RDWAIT -> w_ack=0, w_din=0, FSM in W_IDLE; a fresh w_req after release completes normally.
- w_req held high through W_ACK and W_TURN -> exactly one SRAM access per request; a second access starts only from W_IDLE.
